// File: rtl/dmem_sram_bridge_if.sv
// rtl/dmem_sram_bridge_if.sv - SRAM-like data bus (request/addr_ok/data_ok) between bridge and memory system
interface dmem_sram_bridge_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/dmem_sram_bridge.sv
// rtl/dmem_sram_bridge.sv - issues one SRAM-like transaction per memory-stage access and stalls until it completes
module dmem_sram_bridge (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m_data_req,
    input  logic                      m_data_wr,
    input  logic [1:0]                m_data_size,
    input  logic [31:0]               m_data_addr,
    input  logic [31:0]               m_data_wdata,
    input  logic                      exc_flush,
    input  logic                      pipe_advance,
    output logic [31:0]               m_rdata,
    output logic                      m_busy,
    dmem_sram_bridge_if.master        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        issue_idle;

    assign issue_idle = (state == S_IDLE) && m_data_req && !exc_flush;

    // Outputs are decoded from the state register; IDLE passes the request through
    // so a zero-wait bus can accept in the issue cycle.
    always_comb begin
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_size  = 2'd0;
        bus.data_addr  = 32'd0;
        bus.data_wdata = 32'd0;
        m_busy         = 1'b0;
        m_rdata        = 32'd0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    bus.data_req   = issue_idle;
                    bus.data_wr    = m_data_wr;
                    bus.data_size  = m_data_size;
                    bus.data_addr  = m_data_addr;
                    bus.data_wdata = m_data_wdata;
                    m_busy         = issue_idle;
                    m_rdata        = rdata_q;
                end
                S_REQ: begin
                    bus.data_req   = 1'b1;
                    bus.data_wr    = wr_q;
                    bus.data_size  = size_q;
                    bus.data_addr  = addr_q;
                    bus.data_wdata = wdata_q;
                    m_busy         = 1'b1;
                    m_rdata        = rdata_q;
                end
                S_WAIT: begin
                    bus.data_wr    = wr_q;
                    bus.data_size  = size_q;
                    bus.data_addr  = addr_q;
                    bus.data_wdata = wdata_q;
                    m_busy         = !bus.data_data_ok;
                    m_rdata        = bus.data_data_ok ? bus.data_rdata : rdata_q;
                end
                default: begin
                    bus.data_wr    = wr_q;
                    bus.data_size  = size_q;
                    bus.data_addr  = addr_q;
                    bus.data_wdata = wdata_q;
                    m_rdata        = rdata_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue_idle) begin
                        // Latch on every issue so WAIT/DONE present a stable bus view.
                        wr_q    <= m_data_wr;
                        size_q  <= m_data_size;
                        addr_q  <= m_data_addr;
                        wdata_q <= m_data_wdata;
                        state   <= bus.data_addr_ok ? S_WAIT : S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.data_addr_ok) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.data_data_ok) begin
                        rdata_q <= bus.data_rdata;
                        state   <= pipe_advance ? S_IDLE : S_DONE;
                    end
                end
                S_DONE: begin
                    // m_data_req is still high here; the access is finished, so never re-issue.
                    if (pipe_advance) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_sram_bridge.md
# dmem_sram_bridge

Data-side SRAM-like transaction controller between the memory stage and the data bus. Turns the memory stage's level-held `m_data_*` request into exactly one SRAM-like transaction (`addr_ok`/`data_ok` handshake). While the access is in flight it raises a stall request, and it holds the load data until the pipeline advances. Sits directly downstream of the memory stage and upstream of the cache/AXI bridge.

## Interface
Parameters:
- none (data and address are fixed at 32 bits, size at 2 bits)

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge
- `rst`  in  1  — synchronous, active-high reset
- `m_data_req`  in  1  — memory-stage access request, held level while the instruction sits in the stage
- `m_data_wr`  in  1  — 1 = store
- `m_data_size`  in  2  — 0 = byte, 1 = half, 2 = word
- `m_data_addr`  in  32  — byte address
- `m_data_wdata`  in  32  — store data, already lane-adjusted
- `exc_flush`  in  1  — memory-stage exception; suppresses a not-yet-issued access
- `pipe_advance`  in  1  — memory stage hands its instruction to writeback this cycle
- `data_req`  out  1  — bus request
- `data_wr`  out  1  — bus write enable
- `data_size`  out  2  — bus size
- `data_addr`  out  32  — bus address
- `data_wdata`  out  32  — bus write data
- `data_addr_ok`  in  1  — bus accepted address/request
- `data_data_ok`  in  1  — bus returned data (load) or write completed
- `data_rdata`  in  32  — bus read data, valid with `data_data_ok`
- `m_rdata`  out  32  — load data to the memory stage
- `m_busy`  out  1  — stall request to the hazard unit

## Operation
The controller is a four-state FSM: IDLE, REQ, WAIT, DONE.

- **IDLE**
  - `data_req` = `m_data_req & ~exc_flush`; bus fields pass through combinationally from `m_data_*`.
  - If `data_req` and `data_addr_ok` → WAIT.
  - If `data_req` and not `data_addr_ok` → REQ. Latch wr/size/addr/wdata into holding registers.
- **REQ**
  - `data_req` = 1; bus fields come from the holding registers.
  - The request is never withdrawn: `exc_flush` and input changes are ignored.
  - On `data_addr_ok` → WAIT.
- **WAIT**
  - `data_req` = 0.
  - On `data_data_ok`: capture `data_rdata` into `rdata_q`. Then → IDLE if `pipe_advance`, else → DONE.
- **DONE**
  - The access is complete and no re-issue happens, even though `m_data_req` is still high because another stall source is holding the stage.
  - On `pipe_advance` → IDLE.

Outputs and edge rules:
- `m_busy` = (IDLE & `data_req`) | REQ | (WAIT & ~`data_data_ok`).
- `m_rdata` = `data_rdata` when in WAIT & `data_data_ok`, else `rdata_q`.
- `exc_flush` during WAIT or DONE does not cancel anything; the outstanding transaction completes normally.
- `data_data_ok` in IDLE, REQ or DONE is ignored.
- `pipe_advance` in REQ, or in WAIT without `data_data_ok`, is ignored; it is illegal while `m_busy` is high.
- Stores follow the same flow. `rdata_q` is updated with whatever `data_rdata` holds; the pipeline ignores it for stores.

## Timing
- **Reset values:** state = IDLE; `rdata_q` and holding registers = 0. While `rst` is high, `data_req` = 0 and `m_busy` = 0. All other outputs are 0 while `rst` is high.
- **Reset mid-operation** (REQ, WAIT or DONE): return to IDLE next edge. Any outstanding bus response is discarded; the bus is reset by the same `rst`.
- **Best case:** `addr_ok` in the issue cycle T, `data_ok` at T+1.
  - `m_busy` is high at T and low at T+1.
  - `m_rdata` is valid at T+1 through the bypass path and from `rdata_q` thereafter.
- **Latency:** `m_busy` stays high for (cycles to `addr_ok`) + (cycles to `data_ok`). It always drops in the same cycle that `data_data_ok` arrives.
- **Issue count:** exactly one `data_req` & `data_addr_ok` handshake per memory-stage instruction.
- **Back-to-back accesses:** the next access can issue in the cycle after `pipe_advance`.

## Test plan
- **Zero-wait load:** load at addr 0x8000_0010, size 2. `addr_ok` same cycle, `data_ok` next cycle with 0xDEAD_BEEF, `pipe_advance` then. Required: one handshake, `m_busy` high for 1 cycle, `m_rdata` = 0xDEAD_BEEF.
- **Delayed accept:** `addr_ok` withheld 3 cycles while inputs change to addr 0x0. Required: `data_req` held 4 cycles with the original latched addr 0x8000_0010; `m_busy` drops on `data_ok`.
- **Flush before issue vs after issue:**
  - `exc_flush` = 1 with `m_data_req` in IDLE → `data_req` = 0, `m_busy` = 0.
  - `exc_flush` raised in REQ → request still held until `addr_ok`; the transaction completes.
- **Hold after completion:** `data_ok` with 0x1234_5678, then `pipe_advance` low for 5 cycles. Required: no second `data_req`; `m_rdata` stays 0x1234_5678; `m_busy` = 0.
- **Store:** store 0xAABB_CCDD, size 0, addr 0x1F03. Required: `data_wr` = 1 and fields match on the handshake; `m_busy` drops on `data_ok`.
- **Reset in WAIT:** assert `rst` for one cycle. Required: IDLE next edge; `m_busy` = 0; a late `data_ok` is ignored; `m_rdata` = 0.
